// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: runs MIPS MULTU/DIVU over 32 cycles on the shared ALU.
// The result builds up in HI/LO: shift-add for multiply, restoring division for divide.
// Optional feature macro: MULDIV_SIGNED_EN.
//   It adds the signedOp input and a one-cycle FIXUP state that corrects the signs.
// Handshake: start is sampled only in IDLE. busy is high while this block owns the ALU.
//   done pulses for one cycle, and hi/lo are valid from that cycle on.
module alu_muldiv_sequencer #(
  parameter int         ITER    = 32,
  parameter logic [3:0] OP_ADD  = 4'b0010,
  parameter logic [3:0] OP_SUB  = 4'b0110,
  parameter logic [3:0] OP_IDLE = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isDiv,
`ifdef MULDIV_SIGNED_EN
  input  logic        signedOp,
`endif
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] aluOperand1,
  output logic [31:0] aluOperand2,
  output logic [3:0]  aluOperation,
  input  logic [31:0] aluResult,
  input  logic        aluZero,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
`ifdef MULDIV_SIGNED_EN
    , S_FIXUP = 2'd3
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          div_q, div_d;
  logic [31:0]   mag_a, mag_b, r_shift;
  logic          carry, ge;
  logic          zero_unused;
`ifdef MULDIV_SIGNED_EN
  logic          sgn_x_q, sgn_x_d, sgn_a_q, sgn_a_d;
  logic [63:0]   neg_prod;
`endif

  // The zero flag is only watched by the rest of the datapath.
  assign zero_unused = aluZero;

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;
`ifdef MULDIV_SIGNED_EN
  assign busy      = (state_q == S_RUN) || (state_q == S_FIXUP);
  assign mag_a     = (signedOp && srcA[31]) ? (~srcA + 32'd1) : srcA;
  assign mag_b     = (signedOp && srcB[31]) ? (~srcB + 32'd1) : srcB;
  assign neg_prod  = ~{hi_q, lo_q} + 64'd1;
`else
  assign busy      = (state_q == S_RUN);
  assign mag_a     = srcA;
  assign mag_b     = srcB;
`endif

  // These compares are local. They recover the carry and borrow bits that the 32-bit ALU result drops.
  assign r_shift = {hi_q[30:0], lo_q[31]};
  assign carry   = (aluResult < hi_q);
  assign ge      = hi_q[31] | (r_shift >= b_q);

  // Next-state logic, datapath update and ALU drive; the ALU idles outside RUN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    a_d          = a_q;
    b_d          = b_q;
    div_d        = div_q;
    aluOperand1  = 32'd0;
    aluOperand2  = 32'd0;
    aluOperation = OP_IDLE;
`ifdef MULDIV_SIGNED_EN
    sgn_x_d      = sgn_x_q;
    sgn_a_d      = sgn_a_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = mag_a;
          b_d   = mag_b;
          div_d = isDiv;
`ifdef MULDIV_SIGNED_EN
          sgn_x_d = signedOp & (srcA[31] ^ srcB[31]);
          sgn_a_d = signedOp & srcA[31];
`endif
          if (isDiv && (srcB == 32'd0)) begin
            // Divide by zero skips the iterations and returns a fixed result.
            hi_d    = srcA;
            lo_d    = 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else begin
            hi_d    = 32'd0;
            lo_d    = isDiv ? mag_a : mag_b;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (div_q) begin
          aluOperation = OP_SUB;
          aluOperand1  = r_shift;
          aluOperand2  = b_q;
          hi_d         = ge ? aluResult : r_shift;
          lo_d         = {lo_q[30:0], ge};
        end else begin
          aluOperation = OP_ADD;
          aluOperand1  = hi_q;
          aluOperand2  = lo_q[0] ? a_q : 32'd0;
          hi_d         = {carry, aluResult[31:1]};
          lo_d         = {aluResult[0], lo_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
`ifdef MULDIV_SIGNED_EN
          state_d = S_FIXUP;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIXUP: begin
        if (div_q) begin
          if (sgn_x_q) lo_d = ~lo_q + 32'd1;
          if (sgn_a_q) hi_d = ~hi_q + 32'd1;
        end else if (sgn_x_q) begin
          {hi_d, lo_d} = neg_prod;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; a synchronous reset drops any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      div_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_x_q <= 1'b0;
      sgn_a_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
`ifdef MULDIV_SIGNED_EN
      sgn_x_q <= sgn_x_d;
      sgn_a_q <= sgn_a_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer. A behavioural ALU stands beside the DUT.
// Expected {hi,lo} values come from plain * / % arithmetic.
module tb_alu_muldiv_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        reset, start, isDiv;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] hi, lo, aluOperand1, aluOperand2, aluResult;
  logic [3:0]  aluOperation;
  logic        aluZero;
  logic [1:0]  dbg_state;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [3:0]  exp_op = OP_ADD;

  alu_muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .isDiv(isDiv),
`ifdef MULDIV_SIGNED_EN
    .signedOp(1'b0),
`endif
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .aluOperand1(aluOperand1), .aluOperand2(aluOperand2),
    .aluOperation(aluOperation), .aluResult(aluResult), .aluZero(aluZero),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural shared ALU
  always_comb begin
    case (aluOperation)
      OP_ADD:  aluResult = aluOperand1 + aluOperand2;
      OP_SUB:  aluResult = aluOperand1 - aluOperand2;
      default: aluResult = aluOperand1 & aluOperand2;
    endcase
    aluZero = (aluResult == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every done and checks the ALU drive
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (busy) chk("alu_op_run", 64'(aluOperation), 64'(exp_op));
      else begin
        chk("alu_op_idle", 64'(aluOperation), 64'd0);
        chk("alu_opnd_idle", {aluOperand1, aluOperand2}, 64'd0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("result", {hi, lo}, e);
        end
      end
    end
  end

  // driver: issues one operation, optionally pulses start mid-run, and bounds the wait
  task automatic do_op(input logic d, input logic [31:0] a, input logic [31:0] b, input int glitch);
    logic [63:0] e;
    int          cnt;
    int          exp_busy;
    bit          seen;
    if (d && b == 32'd0)  e = {a, 32'hFFFF_FFFF};
    else if (d)           e = {a % b, a / b};
    else                  e = {32'd0, a} * {32'd0, b};
    exp_busy = (d && b == 32'd0) ? 0 : 32;
    exp_q.push_back(e);
    exp_op = d ? OP_SUB : OP_ADD;
    @(negedge clk);
    start = 1'b1; isDiv = d; srcA = a; srcB = b;
    @(posedge clk);
    #1;
    start = 1'b0; isDiv = 1'($urandom); srcA = $urandom; srcB = $urandom;
    cnt = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (busy) cnt++;
      if (glitch > 0 && cnt == glitch) begin
        start = 1'b1; isDiv = ~d; srcA = $urandom; srcB = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(cnt), 64'(exp_busy));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  // mid-run reset: no done may follow, and the registers clear
  task automatic reset_mid_run();
    int cnt;
    exp_op = OP_ADD;
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; srcA = 32'd7; srcB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 10; i++) begin
      if (busy) cnt++;
      if (cnt < 10) @(negedge clk);
    end
    chk("reach_iter10", 64'(cnt), 64'd10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        d;
    reset = 1'b1; start = 1'b0; isDiv = 1'b0; srcA = 32'd0; srcB = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_aluop", 64'(aluOperation), 64'd0);
    chk("rst_opnd", {aluOperand1, aluOperand2}, 64'd0);
    reset = 1'b0;

    do_op(1'b0, 32'd5, 32'd6, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'd15, 32'd16, 0);
    do_op(1'b1, 32'hAAAA_AAAA, 32'd0, 0);
    do_op(1'b0, 32'h0001_2345, 32'h0000_6789, 5);
    do_op(1'b1, 32'hDEAD_BEEF, 32'd13, 20);
    reset_mid_run();
    do_op(1'b0, 32'd3, 32'd4, 0);

    for (int i = 0; i < 14; i++) begin
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 15);
        1:       b = $urandom;
        2:       b = a >> $urandom_range(0, 8);
        default: b = 32'd0;
      endcase
      do_op(d, a, b, 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
